fp_alu_issue_ctrl: RTL and testbench
====================================

# fp_alu_issue_ctrl

Sequential front end for the combinational floating-point ALU. It accepts operation requests over a valid/ready handshake and registers the opcode and operands that drive the ALU's inputs. It holds those inputs stable for a fixed settle window, then captures the ALU result and flags into a response register presented over a second valid/ready handshake. The block sits directly upstream of the ALU: its operand registers drive `ALU_Op`/`data_iA`/`data_iB`, and it consumes `data_o`/`flg_negative`/`flg_zero`.

## Interface
- `DATAWIDTH`, 32: operand/result width, IEEE-754 single precision.
- `SETTLE_CYCLES`, 4: number of clock cycles the ALU inputs are held before capture; legal range 1..15.

- `Clk`  in  1  clock, rising edge.
- `Rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_op`  in  2  opcode: 00 add, 01 sub, 10 mul, 11 div.
- `req_dataA`, `req_dataB`  in  DATAWIDTH  operands.
- `alu_op`  out  2  to ALU `ALU_Op`.
- `alu_dataA`, `alu_dataB`  out  DATAWIDTH  to ALU `data_iA`/`data_iB`.
- `alu_data_i`  in  DATAWIDTH  from ALU `data_o`.
- `alu_flg_negative`, `alu_flg_zero`  in  1  from ALU flags.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_data`  out  DATAWIDTH  captured result.
- `rsp_flg_negative`, `rsp_flg_zero`  out  1  captured flags.
- `rsp_flg_invalid`  out  1  captured result is Inf/NaN (see Configuration).

## Operation
- The FSM has three states: IDLE, SETTLE, RESP. A 4-bit down-counter `cnt` times the settle window.
- IDLE:
  - `req_ready`=1.
  - When `req_valid` is high, latch `req_op`/`req_dataA`/`req_dataB` into the ALU operand registers, load `cnt`=SETTLE_CYCLES-1, and go to SETTLE.
- SETTLE:
  - `req_ready`=0 and `req_valid` is ignored.
  - If `cnt`≠0, decrement.
  - If `cnt`=0, capture `alu_data_i` and both flags into the response registers and go to RESP.
- RESP:
  - `rsp_valid`=1, and response registers are held.
  - When `rsp_ready` is high, go to IDLE.
  - A new request is not accepted in the same cycle as the response handshake.
- The ALU operand registers hold their value from acceptance until the next accepted request; they are never cleared by the response handshake.
- Response registers change only at capture or reset.
- `req_ready` and `rsp_valid` are decoded from state only, with no combinational path from `req_valid` or `rsp_ready`.
- Reset (any state, any time):
  - state is IDLE and `cnt`=0.
  - `alu_op`, `alu_dataA`, `alu_dataB`, `rsp_data` and all `rsp_flg_*` are 0.
  - `rsp_valid`=0 and `req_ready`=1.
  - A reset during SETTLE or RESP discards the operation and produces no response.

## Timing
- If a request is accepted at edge k, the ALU inputs change after edge k.
- Capture happens at edge k+SETTLE_CYCLES, and `rsp_valid` is high from that edge.
- With SETTLE_CYCLES=1, `rsp_valid` rises one edge after acceptance.
- If the response handshake completes at edge m, `req_ready` is high after edge m, and the next acceptance is at edge m+1 at the earliest.
- Throughput with `rsp_ready` tied high is one operation per SETTLE_CYCLES+2 cycles.
- SETTLE_CYCLES must cover the ALU's worst-case combinational delay; it is chosen by the integrator.

## Configuration
- `FP_EXC_DETECT_EN` defined:
  - At capture, `rsp_flg_invalid` = 1 when exponent bits [30:23] of `alu_data_i` are all ones (Inf or NaN), otherwise 0.
  - It is registered alongside the other flags.
- `FP_EXC_DETECT_EN` undefined:
  - `rsp_flg_invalid` is tied to 0.
  - No exponent-detect logic is present.
  - The port still exists.

## Test plan
Each scenario uses a bench ALU model or the real ALU, with SETTLE_CYCLES=4 unless stated.
1. **Reset:** assert `Rst_n`=0 mid-SETTLE → all outputs 0 except `req_ready`=1; after release, no `rsp_valid` ever appears for the aborted op.
2. **Add with latency check:** op 00, A=0xBFA00000, B=0x3FA00000, accepted at edge k → `rsp_valid` rises at k+4; `rsp_data`=0x00000000, `rsp_flg_zero`=1, `rsp_flg_negative`=0.
3. **Sub under back-pressure:** op 01 with the same operands, `rsp_ready`=0 for 10 cycles, `req_valid` held high with other data → `rsp_data`=0xC0200000 and `rsp_flg_negative`=1, both stable; `req_ready`=0 throughout; the extra request is not latched.
4. **Back-to-back with `rsp_ready`=1:** op 10 then op 11 with the same operands → responses 0xBFC80000 then 0xBF800000; second acceptance is exactly one edge after the first response handshake; spacing is 6 cycles.
5. **Minimum settle:** SETTLE_CYCLES=1, op 00, A=0x3F800000, B=0x3F800000 → `rsp_valid` one edge after acceptance, `rsp_data`=0x40000000.
6. **Exception flag:** op 00, A=0x7F800000, B=0x3F800000 → `rsp_data`=0x7F800000; `rsp_flg_invalid`=1 with `FP_EXC_DETECT_EN` defined, 0 without it.

Source files
------------

// File: rtl/fp_alu_issue_ctrl.sv
// Issue/capture front end for the combinational FP ALU: registers operands, holds them for a settle window, captures the result.
// Optional build macro FP_EXC_DETECT_EN: when defined, rsp_flg_invalid flags Inf/NaN results (exponent all ones).
module fp_alu_issue_ctrl #(
  parameter int DATAWIDTH     = 32,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [DATAWIDTH-1:0] req_dataA,
  input  logic [DATAWIDTH-1:0] req_dataB,
  output logic [1:0]           alu_op,
  output logic [DATAWIDTH-1:0] alu_dataA,
  output logic [DATAWIDTH-1:0] alu_dataB,
  input  logic [DATAWIDTH-1:0] alu_data_i,
  input  logic                 alu_flg_negative,
  input  logic                 alu_flg_zero,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATAWIDTH-1:0] rsp_data,
  output logic                 rsp_flg_negative,
  output logic                 rsp_flg_zero,
  output logic                 rsp_flg_invalid
);

  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, RESP = 2'd2} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t               state_reg, state_next;
  logic [3:0]           cnt_reg, cnt_next;
  logic                 accept, capture;
  logic [1:0]           op_reg;
  logic [DATAWIDTH-1:0] data_a_reg, data_b_reg, rsp_data_reg;
  logic                 rsp_neg_reg, rsp_zero_reg;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Handshake outputs depend on state only, never on req_valid/rsp_ready.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    capture    = 1'b0;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept     = 1'b1;
          cnt_next   = CNT_LOAD;
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_reg != 4'd0) begin
          cnt_next = cnt_reg - 4'd1;
        end else begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand registers persist until the next accepted request.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      op_reg     <= 2'd0;
      data_a_reg <= '0;
      data_b_reg <= '0;
    end else if (accept) begin
      op_reg     <= req_op;
      data_a_reg <= req_dataA;
      data_b_reg <= req_dataB;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rsp_data_reg <= '0;
      rsp_neg_reg  <= 1'b0;
      rsp_zero_reg <= 1'b0;
    end else if (capture) begin
      rsp_data_reg <= alu_data_i;
      rsp_neg_reg  <= alu_flg_negative;
      rsp_zero_reg <= alu_flg_zero;
    end
  end

`ifdef FP_EXC_DETECT_EN
  logic rsp_inv_reg;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)       rsp_inv_reg <= 1'b0;
    else if (capture) rsp_inv_reg <= &alu_data_i[30:23];
  end

  assign rsp_flg_invalid = rsp_inv_reg;
`else
  assign rsp_flg_invalid = 1'b0;
`endif

  assign alu_op           = op_reg;
  assign alu_dataA        = data_a_reg;
  assign alu_dataB        = data_b_reg;
  assign rsp_data         = rsp_data_reg;
  assign rsp_flg_negative = rsp_neg_reg;
  assign rsp_flg_zero     = rsp_zero_reg;

endmodule

// File: tb/tb_fp_alu_issue_ctrl.sv
// Directed bench for fp_alu_issue_ctrl: table of FP vectors against a lookup ALU model, plus timing/corner sequences.
module tb_fp_alu_issue_ctrl;

  localparam int SC = 4;
`ifdef FP_EXC_DETECT_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  // Main instance, SETTLE_CYCLES=4
  logic        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [1:0]  req_op, alu_op;
  logic [31:0] req_dataA, req_dataB, alu_dataA, alu_dataB, alu_data_i, rsp_data;
  logic        alu_flg_negative, alu_flg_zero;
  logic        rsp_flg_negative, rsp_flg_zero, rsp_flg_invalid;

  // Second instance, SETTLE_CYCLES=1
  logic        m_req_valid, m_req_ready, m_rsp_valid, m_rsp_ready;
  logic [1:0]  m_req_op, m_alu_op;
  logic [31:0] m_req_dataA, m_req_dataB, m_alu_dataA, m_alu_dataB, m_alu_data_i, m_rsp_data;
  logic        m_alu_flg_negative, m_alu_flg_zero;
  logic        m_rsp_flg_negative, m_rsp_flg_zero, m_rsp_flg_invalid;

  fp_alu_issue_ctrl #(.DATAWIDTH(32), .SETTLE_CYCLES(SC)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_dataA(req_dataA), .req_dataB(req_dataB),
    .alu_op(alu_op), .alu_dataA(alu_dataA), .alu_dataB(alu_dataB),
    .alu_data_i(alu_data_i), .alu_flg_negative(alu_flg_negative), .alu_flg_zero(alu_flg_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_flg_negative(rsp_flg_negative), .rsp_flg_zero(rsp_flg_zero),
    .rsp_flg_invalid(rsp_flg_invalid)
  );

  fp_alu_issue_ctrl #(.DATAWIDTH(32), .SETTLE_CYCLES(1)) dut_min (
    .Clk(Clk), .Rst_n(Rst_n),
    .req_valid(m_req_valid), .req_ready(m_req_ready), .req_op(m_req_op),
    .req_dataA(m_req_dataA), .req_dataB(m_req_dataB),
    .alu_op(m_alu_op), .alu_dataA(m_alu_dataA), .alu_dataB(m_alu_dataB),
    .alu_data_i(m_alu_data_i), .alu_flg_negative(m_alu_flg_negative), .alu_flg_zero(m_alu_flg_zero),
    .rsp_valid(m_rsp_valid), .rsp_ready(m_rsp_ready), .rsp_data(m_rsp_data),
    .rsp_flg_negative(m_rsp_flg_negative), .rsp_flg_zero(m_rsp_flg_zero),
    .rsp_flg_invalid(m_rsp_flg_invalid)
  );

  // Lookup-table ALU: only the operand combinations used by this bench are known.
  function automatic logic [31:0] alu_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [65:0] key;
    key = {op, a, b};
    case (key)
      {2'b00, 32'hBFA00000, 32'h3FA00000}: return 32'h00000000;
      {2'b01, 32'hBFA00000, 32'h3FA00000}: return 32'hC0200000;
      {2'b10, 32'hBFA00000, 32'h3FA00000}: return 32'hBFC80000;
      {2'b11, 32'hBFA00000, 32'h3FA00000}: return 32'hBF800000;
      {2'b00, 32'h3F800000, 32'h3F800000}: return 32'h40000000;
      {2'b01, 32'h3F800000, 32'h3F800000}: return 32'h00000000;
      {2'b00, 32'h7F800000, 32'h3F800000}: return 32'h7F800000;
      default:                             return 32'hDEADBEEF;
    endcase
  endfunction

  always_comb begin
    alu_data_i         = alu_model(alu_op, alu_dataA, alu_dataB);
    alu_flg_negative   = alu_data_i[31];
    alu_flg_zero       = (alu_data_i[30:0] == 31'd0);
    m_alu_data_i       = alu_model(m_alu_op, m_alu_dataA, m_alu_dataB);
    m_alu_flg_negative = m_alu_data_i[31];
    m_alu_flg_zero     = (m_alu_data_i[30:0] == 31'd0);
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] data;
    logic        neg;
    logic        zero;
    logic        inv;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int lat;
    int bad_ready;
    int stable_err;
    int cyc;
    int n_acc;
    int n_rsp;
    int acc_cyc[2];
    int rsp_cyc[2];
    logic [31:0] rsp_d[2];
    logic fire_req;
    logic fire_rsp;
    int spurious;

    vecs[0] = '{2'b00, 32'hBFA00000, 32'h3FA00000, 32'h00000000, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{2'b01, 32'hBFA00000, 32'h3FA00000, 32'hC0200000, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{2'b10, 32'hBFA00000, 32'h3FA00000, 32'hBFC80000, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{2'b11, 32'hBFA00000, 32'h3FA00000, 32'hBF800000, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{2'b00, 32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{2'b01, 32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{2'b00, 32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b0, 1'b0, EXC_EN};

    req_valid = 1'b0; rsp_ready = 1'b0; req_op = 2'b00; req_dataA = '0; req_dataB = '0;
    m_req_valid = 1'b0; m_rsp_ready = 1'b0; m_req_op = 2'b00; m_req_dataA = '0; m_req_dataB = '0;

    // Reset state
    repeat (2) @(posedge Clk);
    #1;
    check_bit("rst_req_ready", req_ready, 1'b1);
    check_bit("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_alu_dataA", alu_dataA, 32'h0);
    check("rst_rsp_data", rsp_data, 32'h0);
    Rst_n = 1'b1;
    tick;

    // Table-driven single transactions with rsp_ready asserted after capture
    for (int i = 0; i < 7; i++) begin
      req_op = vecs[i].op; req_dataA = vecs[i].a; req_dataB = vecs[i].b; req_valid = 1'b1;
      check_bit("vec_req_ready", req_ready, 1'b1);
      tick;
      req_valid = 1'b0;
      check("vec_alu_op", 32'(alu_op), 32'(vecs[i].op));
      check("vec_alu_dataA", alu_dataA, vecs[i].a);
      check("vec_alu_dataB", alu_dataB, vecs[i].b);
      lat = 0;
      while (!rsp_valid && lat < 40) begin
        tick;
        lat++;
      end
      check("vec_latency", 32'(lat), 32'(SC));
      check("vec_rsp_data", rsp_data, vecs[i].data);
      check_bit("vec_rsp_neg", rsp_flg_negative, vecs[i].neg);
      check_bit("vec_rsp_zero", rsp_flg_zero, vecs[i].zero);
      check_bit("vec_rsp_inv", rsp_flg_invalid, vecs[i].inv);
      $display("[TB] vec %0d op=%0d A=%h B=%h rsp=%h neg=%b zero=%b inv=%b lat=%0d",
               i, vecs[i].op, vecs[i].a, vecs[i].b, rsp_data, rsp_flg_negative, rsp_flg_zero, rsp_flg_invalid, lat);
      rsp_ready = 1'b1;
      tick;
      rsp_ready = 1'b0;
      check_bit("vec_rsp_drop", rsp_valid, 1'b0);
      check_bit("vec_ready_back", req_ready, 1'b1);
    end

    // Sub under back-pressure with a competing request held on the input
    req_op = 2'b01; req_dataA = 32'hBFA00000; req_dataB = 32'h3FA00000; req_valid = 1'b1;
    tick;
    req_op = 2'b10; req_dataA = 32'h12345678; req_dataB = 32'h9ABCDEF0;
    bad_ready = 0; stable_err = 0; lat = 0;
    while (!rsp_valid && lat < 40) begin
      if (req_ready) bad_ready++;
      tick;
      lat++;
    end
    check("bp_latency", 32'(lat), 32'(SC));
    for (int c = 0; c < 10; c++) begin
      if (req_ready) bad_ready++;
      if (!rsp_valid || rsp_data !== 32'hC0200000 || rsp_flg_negative !== 1'b1) stable_err++;
      if (alu_dataA !== 32'hBFA00000 || alu_op !== 2'b01) stable_err++;
      tick;
    end
    check("bp_req_ready_low", 32'(bad_ready), 32'd0);
    check("bp_stable", 32'(stable_err), 32'd0);
    check("bp_rsp_data", rsp_data, 32'hC0200000);
    check_bit("bp_rsp_neg", rsp_flg_negative, 1'b1);
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    check("bp_no_latch_hs", alu_dataA, 32'hBFA00000);
    check_bit("bp_ready_after_hs", req_ready, 1'b1);
    req_valid = 1'b0;
    tick;
    check("bp_no_latch_after", alu_dataA, 32'hBFA00000);
    check_bit("bp_idle_rsp_valid", rsp_valid, 1'b0);
    $display("[TB] backpressure sub rsp=%h alu_dataA=%h", rsp_data, alu_dataA);

    // Back-to-back mul then div with rsp_ready tied high
    req_op = 2'b10; req_dataA = 32'hBFA00000; req_dataB = 32'h3FA00000; req_valid = 1'b1;
    rsp_ready = 1'b1;
    cyc = 0; n_acc = 0; n_rsp = 0;
    acc_cyc = '{0, 0}; rsp_cyc = '{0, 0}; rsp_d = '{32'h0, 32'h0};
    while (n_rsp < 2 && cyc < 60) begin
      fire_req = req_valid && req_ready;
      fire_rsp = rsp_valid && rsp_ready;
      if (fire_rsp) begin
        rsp_cyc[n_rsp] = cyc;
        rsp_d[n_rsp] = rsp_data;
        n_rsp++;
      end
      if (fire_req && n_acc < 2) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end
      tick;
      cyc++;
      if (fire_req) begin
        if (n_acc == 1) req_op = 2'b11;
        else req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    check("b2b_rsp_count", 32'(n_rsp), 32'd2);
    check("b2b_rsp0", rsp_d[0], 32'hBFC80000);
    check("b2b_rsp1", rsp_d[1], 32'hBF800000);
    check("b2b_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);
    check("b2b_accept_after_hs", 32'(acc_cyc[1]), 32'(rsp_cyc[0] + 1));
    $display("[TB] back-to-back acc=%0d,%0d hs=%0d,%0d rsp=%h,%h",
             acc_cyc[0], acc_cyc[1], rsp_cyc[0], rsp_cyc[1], rsp_d[0], rsp_d[1]);

    // Minimum settle window on the SETTLE_CYCLES=1 instance
    m_req_op = 2'b00; m_req_dataA = 32'h3F800000; m_req_dataB = 32'h3F800000; m_req_valid = 1'b1;
    tick;
    m_req_valid = 1'b0;
    lat = 0;
    while (!m_rsp_valid && lat < 40) begin
      tick;
      lat++;
    end
    check("min_latency", 32'(lat), 32'd1);
    check("min_rsp_data", m_rsp_data, 32'h40000000);
    check_bit("min_rsp_zero", m_rsp_flg_zero, 1'b0);
    $display("[TB] min settle rsp=%h lat=%0d", m_rsp_data, lat);
    m_rsp_ready = 1'b1;
    tick;
    m_rsp_ready = 1'b0;
    check_bit("min_ready_back", m_req_ready, 1'b1);

    // Asynchronous reset in the middle of SETTLE
    req_op = 2'b01; req_dataA = 32'hBFA00000; req_dataB = 32'h3FA00000; req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    tick;
    tick;
    #2 Rst_n = 1'b0;
    #1;
    check_bit("arst_req_ready", req_ready, 1'b1);
    check_bit("arst_rsp_valid", rsp_valid, 1'b0);
    check("arst_alu_op", 32'(alu_op), 32'd0);
    check("arst_alu_dataA", alu_dataA, 32'h0);
    check("arst_alu_dataB", alu_dataB, 32'h0);
    check("arst_rsp_data", rsp_data, 32'h0);
    check_bit("arst_rsp_neg", rsp_flg_negative, 1'b0);
    check_bit("arst_rsp_zero", rsp_flg_zero, 1'b0);
    check_bit("arst_rsp_inv", rsp_flg_invalid, 1'b0);
    #3 Rst_n = 1'b1;
    spurious = 0;
    for (int c = 0; c < 12; c++) begin
      tick;
      if (rsp_valid) spurious++;
    end
    check("arst_no_response", 32'(spurious), 32'd0);
    check_bit("arst_idle_ready", req_ready, 1'b1);
    $display("[TB] reset mid-settle spurious_rsp=%0d", spurious);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
